// File: rtl/bus_sequencer.sv
// Microcoded T-state sequencer for a simple accumulator CPU: steps T0..T4 and
// decodes bus driver enables and capture strobes from T-state and opcode.
module bus_sequencer #(
    parameter int unsigned OPW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic [OPW-1:0] ir_opcode,
    input  logic           c_zero,
    output logic           pc_oe,
    output logic           ram_oe,
    output logic           ir_oe,
    output logic           c_oe,
    output logic           pc_ld,
    output logic           pc_inc,
    output logic           mar_ld,
    output logic           ram_we,
    output logic           ir_ld,
    output logic           b_ld,
    output logic           c_ld,
    output logic           out_ld,
    output logic           c_sel,
    output logic           alu_sub,
    output logic           halted,
    output logic [2:0]     tstate
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_t;

    localparam logic [OPW-1:0] OP_LDA = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(3);
    localparam logic [OPW-1:0] OP_STA = OPW'(4);
    localparam logic [OPW-1:0] OP_LDI = OPW'(5);
    localparam logic [OPW-1:0] OP_JMP = OPW'(6);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(7);
    localparam logic [OPW-1:0] OP_OUT = OPW'(8);
    localparam logic [OPW-1:0] OP_HLT = OPW'(15);

    tstate_t r_state;
    tstate_t w_next;
    logic    r_halted;
    logic    w_halt_set;
    logic    w_en;

    // Reset is included so the combinational strobes stay low while it is held.
    assign w_en   = run & ~r_halted & ~reset;
    assign halted = r_halted;
    assign tstate = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= T0;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_halt_set) begin
                r_halted <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_halt_set = 1'b0;
        pc_oe      = 1'b0;
        ram_oe     = 1'b0;
        ir_oe      = 1'b0;
        c_oe       = 1'b0;
        pc_ld      = 1'b0;
        pc_inc     = 1'b0;
        mar_ld     = 1'b0;
        ram_we     = 1'b0;
        ir_ld      = 1'b0;
        b_ld       = 1'b0;
        c_ld       = 1'b0;
        out_ld     = 1'b0;
        c_sel      = 1'b0;
        alu_sub    = 1'b0;
        if (w_en) begin
            case (r_state)
                T0: begin
                    pc_oe  = 1'b1;
                    mar_ld = 1'b1;
                    w_next = T1;
                end
                T1: begin
                    ram_oe = 1'b1;
                    ir_ld  = 1'b1;
                    pc_inc = 1'b1;
                    w_next = T2;
                end
                T2: begin
                    w_next = T0;
                    case (ir_opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_oe  = 1'b1;
                            mar_ld = 1'b1;
                            w_next = T3;
                        end
                        OP_LDI: begin
                            ir_oe = 1'b1;
                            c_ld  = 1'b1;
                            c_sel = 1'b1;
                        end
                        OP_JMP: begin
                            ir_oe = 1'b1;
                            pc_ld = 1'b1;
                        end
                        OP_JZ: begin
                            ir_oe = c_zero;
                            pc_ld = c_zero;
                        end
                        OP_OUT: begin
                            c_oe   = 1'b1;
                            out_ld = 1'b1;
                        end
                        OP_HLT:  w_halt_set = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    w_next = T0;
                    case (ir_opcode)
                        OP_LDA: begin
                            ram_oe = 1'b1;
                            c_ld   = 1'b1;
                            c_sel  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_oe = 1'b1;
                            b_ld   = 1'b1;
                            w_next = T4;
                        end
                        OP_STA: begin
                            c_oe   = 1'b1;
                            ram_we = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    w_next = T0;
                    if (ir_opcode == OP_ADD || ir_opcode == OP_SUB) begin
                        c_ld    = 1'b1;
                        alu_sub = (ir_opcode == OP_SUB);
                    end
                end
                default: w_next = T0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: instruction walks, JZ, run freeze,
// async reset, halt, and a random opcode stream invariant check.
module tb_bus_sequencer;

    logic       clk;
    logic       reset;
    logic       run;
    logic [3:0] ir_opcode;
    logic       c_zero;
    logic       pc_oe, ram_oe, ir_oe, c_oe;
    logic       pc_ld, pc_inc, mar_ld, ram_we, ir_ld, b_ld, c_ld, out_ld;
    logic       c_sel, alu_sub, halted;
    logic [2:0] tstate;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    localparam logic [13:0] S_PC_OE   = 14'h2000;
    localparam logic [13:0] S_RAM_OE  = 14'h1000;
    localparam logic [13:0] S_IR_OE   = 14'h0800;
    localparam logic [13:0] S_C_OE    = 14'h0400;
    localparam logic [13:0] S_PC_LD   = 14'h0200;
    localparam logic [13:0] S_PC_INC  = 14'h0100;
    localparam logic [13:0] S_MAR_LD  = 14'h0080;
    localparam logic [13:0] S_RAM_WE  = 14'h0040;
    localparam logic [13:0] S_IR_LD   = 14'h0020;
    localparam logic [13:0] S_B_LD    = 14'h0010;
    localparam logic [13:0] S_C_LD    = 14'h0008;
    localparam logic [13:0] S_OUT_LD  = 14'h0004;
    localparam logic [13:0] S_C_SEL   = 14'h0002;
    localparam logic [13:0] S_ALU_SUB = 14'h0001;
    localparam logic [13:0] S_NONE    = 14'h0000;
    localparam logic [13:0] S_T0      = S_PC_OE | S_MAR_LD;
    localparam logic [13:0] S_T1      = S_RAM_OE | S_IR_LD | S_PC_INC;

    logic [13:0] w_strobes;
    assign w_strobes = {pc_oe, ram_oe, ir_oe, c_oe, pc_ld, pc_inc, mar_ld,
                        ram_we, ir_ld, b_ld, c_ld, out_ld, c_sel, alu_sub};

    bus_sequencer #(.OPW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .ir_opcode (ir_opcode),
        .c_zero    (c_zero),
        .pc_oe     (pc_oe),
        .ram_oe    (ram_oe),
        .ir_oe     (ir_oe),
        .c_oe      (c_oe),
        .pc_ld     (pc_ld),
        .pc_inc    (pc_inc),
        .mar_ld    (mar_ld),
        .ram_we    (ram_we),
        .ir_ld     (ir_ld),
        .b_ld      (b_ld),
        .c_ld      (c_ld),
        .out_ld    (out_ld),
        .c_sel     (c_sel),
        .alu_sub   (alu_sub),
        .halted    (halted),
        .tstate    (tstate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Step one clock; outputs are sampled 2 time units after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_step(input string tag, input logic [2:0] ts, input logic [13:0] st);
        check({tag, "_tstate"}, 16'(tstate), 16'(ts));
        check({tag, "_strobes"}, 16'(w_strobes), 16'(st));
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; ir_opcode = 4'd0; c_zero = 1'b0;
        #3;
        expect_step("reset", 3'd0, S_NONE);
        check("reset_halted", 16'(halted), 16'd0);
        run = 1'b1; ir_opcode = 4'd2;
        #1;
        expect_step("reset_run_high", 3'd0, S_NONE);

        // ADD walk
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        expect_step("add_t0", 3'd0, S_T0);
        cyc(); expect_step("add_t1", 3'd1, S_T1);
        cyc(); expect_step("add_t2", 3'd2, S_IR_OE | S_MAR_LD);
        cyc(); expect_step("add_t3", 3'd3, S_RAM_OE | S_B_LD);
        cyc(); expect_step("add_t4", 3'd4, S_C_LD);
        cyc(); expect_step("add_end", 3'd0, S_T0);

        // LDA walk
        ir_opcode = 4'd1;
        cyc(); expect_step("lda_t1", 3'd1, S_T1);
        cyc(); expect_step("lda_t2", 3'd2, S_IR_OE | S_MAR_LD);
        cyc(); expect_step("lda_t3", 3'd3, S_RAM_OE | S_C_LD | S_C_SEL);
        cyc(); expect_step("lda_end", 3'd0, S_T0);

        // JZ not taken, c_zero toggled outside T2 must not matter
        ir_opcode = 4'd7; c_zero = 1'b1;
        cyc(); expect_step("jz0_t1", 3'd1, S_T1);
        c_zero = 1'b0; #1;
        cyc(); expect_step("jz0_t2", 3'd2, S_NONE);
        cyc(); expect_step("jz0_end", 3'd0, S_T0);
        // JZ taken
        cyc(); expect_step("jz1_t1", 3'd1, S_T1);
        c_zero = 1'b1;
        cyc(); expect_step("jz1_t2", 3'd2, S_IR_OE | S_PC_LD);
        cyc(); expect_step("jz1_end", 3'd0, S_T0);

        // STA with run dropped at T3
        ir_opcode = 4'd4; c_zero = 1'b0;
        cyc(); expect_step("sta_t1", 3'd1, S_T1);
        cyc(); expect_step("sta_t2", 3'd2, S_IR_OE | S_MAR_LD);
        cyc(); expect_step("sta_t3", 3'd3, S_C_OE | S_RAM_WE);
        run = 1'b0; #1;
        expect_step("sta_frozen0", 3'd3, S_NONE);
        for (int i = 0; i < 3; i++) begin
            cyc(); expect_step("sta_frozen", 3'd3, S_NONE);
        end
        run = 1'b1; #1;
        expect_step("sta_resume", 3'd3, S_C_OE | S_RAM_WE);
        cyc(); expect_step("sta_end", 3'd0, S_T0);

        // SUB with async reset mid-cycle at T4
        ir_opcode = 4'd3;
        cyc(); expect_step("sub_t1", 3'd1, S_T1);
        cyc(); expect_step("sub_t2", 3'd2, S_IR_OE | S_MAR_LD);
        cyc(); expect_step("sub_t3", 3'd3, S_RAM_OE | S_B_LD);
        cyc(); expect_step("sub_t4", 3'd4, S_C_LD | S_ALU_SUB);
        reset = 1'b1; #1;
        expect_step("sub_reset", 3'd0, S_NONE);
        cyc(); expect_step("sub_reset_hold", 3'd0, S_NONE);
        reset = 1'b0; #1;
        expect_step("post_reset_t0", 3'd0, S_T0);

        // Random opcode stream: bus contention and illegal state invariants
        for (int i = 0; i < 200; i++) begin
            ir_opcode = 4'($urandom_range(0, 14));
            c_zero    = 1'($urandom_range(0, 1));
            run       = ($urandom_range(0, 7) != 0);
            #1;
            check("rand_oe_onehot", 16'($countones({pc_oe, ram_oe, ir_oe, c_oe}) <= 1), 16'd1);
            check("rand_tstate_legal", 16'(tstate <= 3'd4), 16'd1);
            cyc();
        end

        // Return to T0 then halt
        run = 1'b1; ir_opcode = 4'd0;
        for (int i = 0; i < 6 && tstate != 3'd0; i++) cyc();
        expect_step("hlt_t0", 3'd0, S_T0);
        ir_opcode = 4'd15;
        cyc(); expect_step("hlt_t1", 3'd1, S_T1);
        cyc(); expect_step("hlt_t2", 3'd2, S_NONE);
        check("hlt_t2_halted", 16'(halted), 16'd0);
        cyc();
        check("hlt_halted", 16'(halted), 16'd1);
        expect_step("hlt_after", 3'd0, S_NONE);
        for (int i = 0; i < 10; i++) begin
            ir_opcode = 4'($urandom_range(0, 15));
            cyc(); expect_step("hlt_frozen", 3'd0, S_NONE);
        end
        check("hlt_sticky", 16'(halted), 16'd1);
        reset = 1'b1; #1;
        check("hlt_cleared", 16'(halted), 16'd0);
        cyc();
        reset = 1'b0; ir_opcode = 4'd0; #1;
        expect_step("hlt_restart", 3'd0, S_T0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
